// File: rtl/canny_hyst.sv
// rtl/canny_hyst.sv - Canny double-threshold + hysteresis stage, 3-cycle latency.
// Define HYST_EN to promote weak pixels touching a strong neighbour; otherwise only strong pixels are edges.
module canny_hyst #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] NMS_data,
    input  logic              NMS_hs,
    input  logic              NMS_vs,
    input  logic              NMS_de,
    input  logic [DATA_W-1:0] th_low,
    input  logic [DATA_W-1:0] th_high,
    output logic [DATA_W-1:0] edge_data,
    output logic              edge_hs,
    output logic              edge_vs,
    output logic              edge_de,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic              cnt_valid
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = 16;

    logic              r_vs_d, r_hs_d, r_seen, r_act;
    logic [DATA_W-1:0] r_th_low, r_th_high;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              w_vs_rise, w_eol, w_ovf;
    logic [1:0]        w_cls;

    logic              r1_hs, r1_vs, r1_de, r1_ovf, r1_act, r1_row1, r1_col0, r1_border;
    logic [1:0]        r1_cls;
    logic [AW-1:0]     r1_addr;
    logic              w_ok;
    logic [AW-1:0]     w_addr;
    logic [1:0]        w_top, w_mid, w_top_in;

    logic [1:0]        r_lb1 [IMG_W];
    logic [1:0]        r_lb2 [IMG_W];
    logic [1:0]        r_win [3][3];
    logic              r2_hs, r2_vs, r2_de, r2_ok;
    logic              w_edge;
    logic [CNT_W-1:0]  r_acc;

    assign w_vs_rise = NMS_vs & ~r_vs_d;
    // Line end is taken from hs so that de gaps inside a line do not split it.
    assign w_eol     = NMS_hs & ~r_hs_d & r_seen;
    assign w_ovf     = (r_col == COL_W'(IMG_W));

    always_comb begin
        w_cls = 2'd0;
        if (NMS_data >= r_th_high)
            w_cls = 2'd2;
        else if (NMS_data >= r_th_low)
            w_cls = 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d    <= 1'b0;
            r_hs_d    <= 1'b0;
            r_seen    <= 1'b0;
            r_act     <= 1'b0;
            r_th_low  <= '0;
            r_th_high <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r1_hs     <= 1'b0;
            r1_vs     <= 1'b0;
            r1_de     <= 1'b0;
            r1_ovf    <= 1'b0;
            r1_act    <= 1'b0;
            r1_row1   <= 1'b0;
            r1_col0   <= 1'b0;
            r1_border <= 1'b0;
            r1_cls    <= 2'd0;
            r1_addr   <= '0;
        end else begin
            r_vs_d <= NMS_vs;
            r_hs_d <= NMS_hs;
            if (w_vs_rise) begin
                r_th_low  <= th_low;
                r_th_high <= th_high;
                r_act     <= 1'b1;
                r_row     <= '0;
            end else if (w_eol && r_row != '1) begin
                r_row <= r_row + ROW_W'(1);
            end
            if (w_vs_rise || w_eol) begin
                r_col  <= '0;
                r_seen <= 1'b0;
            end else if (NMS_de) begin
                r_seen <= 1'b1;
                if (!w_ovf)
                    r_col <= r_col + COL_W'(1);
            end
            r1_hs     <= NMS_hs;
            r1_vs     <= NMS_vs;
            r1_de     <= NMS_de;
            r1_ovf    <= w_ovf;
            r1_act    <= r_act;
            r1_row1   <= (r_row == ROW_W'(1));
            r1_col0   <= (r_col == '0);
            r1_border <= (r_row == '0) || (r_col == '0);
            r1_cls    <= NMS_de ? w_cls : 2'd0;
            r1_addr   <= r_col[AW-1:0];
        end
    end

    assign w_ok     = r1_de & ~r1_ovf;
    assign w_addr   = w_ok ? r1_addr : '0;
    assign w_mid    = r_lb1[w_addr];
    assign w_top    = r_lb2[w_addr];
    assign w_top_in = r1_row1 ? 2'd0 : w_top;

    always_ff @(posedge clk) begin
        if (w_ok) begin
            r_lb1[w_addr] <= r1_cls;
            r_lb2[w_addr] <= w_mid;
        end
    end

    // Masking is applied as columns enter the window: zero top row on row 1, zero left history at line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= 2'd0;
            r2_hs <= 1'b0;
            r2_vs <= 1'b0;
            r2_de <= 1'b0;
            r2_ok <= 1'b0;
        end else begin
            if (w_ok) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r1_col0 ? 2'd0 : r_win[i][1];
                    r_win[i][1] <= r1_col0 ? 2'd0 : r_win[i][2];
                end
                r_win[0][2] <= w_top_in;
                r_win[1][2] <= w_mid;
                r_win[2][2] <= r1_cls;
            end
            r2_hs <= r1_hs;
            r2_vs <= r1_vs;
            r2_de <= r1_de;
            r2_ok <= w_ok & r1_act & ~r1_border;
        end
    end

`ifdef HYST_EN
    logic w_strong_nb;

    always_comb begin
        w_strong_nb = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (!(i == 1 && j == 1) && r_win[i][j] == 2'd2)
                    w_strong_nb = 1'b1;
        w_edge = r2_ok && (r_win[1][1] == 2'd2 || (r_win[1][1] == 2'd1 && w_strong_nb));
    end
`else
    always_comb begin
        w_edge = r2_ok && (r_win[1][1] == 2'd2);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_data <= '0;
            edge_hs   <= 1'b0;
            edge_vs   <= 1'b0;
            edge_de   <= 1'b0;
            edge_cnt  <= '0;
            cnt_valid <= 1'b0;
            r_acc     <= '0;
        end else begin
            edge_data <= {DATA_W{w_edge}};
            edge_hs   <= r2_hs;
            edge_vs   <= r2_vs;
            edge_de   <= r2_de;
            cnt_valid <= w_vs_rise;
            if (w_vs_rise) begin
                edge_cnt <= r_acc;
                r_acc    <= '0;
            end else if (w_edge && r_acc != '1) begin
                r_acc <= r_acc + CNT_W'(1);
            end
        end
    end

endmodule
